// File: rtl/jpeg_decoder_output_dma.sv
// jpeg_decoder_output_dma
//   Drains the JPEG decoder output FIFO into memory as AXI4 INCR write bursts.
//   Each burst is sized as min(MAX_BURST, words remaining, words to the next
//   4KB boundary), and AW is issued only once the FIFO already holds the whole
//   burst, so W never starves mid-burst. One burst is outstanding at a time.
//
// Optional feature macro: JPEG_DMA_BRESP_CHECK_EN
//   defined   : SLVERR/DECERR responses set the sticky error_o (cleared by start_i)
//   undefined : axi_bresp_i ignored, error_o tied to 0
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               launch pulse (ignored while busy_o)
//   base_addr_i, words_i  destination byte address (word aligned), word count
//   busy_o, done_o        transfer in progress, one-cycle completion pulse
//   error_o               sticky bus-error flag
//   fifo_*                FIFO head data/valid/level and pop strobe
//   axi_aw*, axi_w*, axi_b*  AXI4 write address, data and response channels
module jpeg_decoder_output_dma #(
    parameter int unsigned AXI_ID    = 0,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [23:0] words_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    input  logic [31:0] fifo_data_i,
    input  logic        fifo_valid_i,
    input  logic [10:0] fifo_level_i,
    output logic        fifo_pop_o,
    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [3:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    input  logic        axi_awready_i,
    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic [3:0]  axi_bid_i,
    output logic        axi_bready_o
);

    typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, RESP} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [23:0] r_remaining;
    logic [8:0]  r_len;
    logic [7:0]  r_awlen;
    logic [7:0]  r_beat;
    logic        r_busy;
    logic        r_done;
    logic        r_awvalid;
    logic        r_bready;

    logic [10:0] w_room;
    logic [8:0]  w_len;
    logic        w_fifo_ok;
    logic        w_in_data;
    logic        w_wvalid;
    logic        w_w_hs;
    logic        w_wlast;
    logic [23:0] w_rem_next;
    logic        w_unused;

    // Words left before the next 4KB boundary: 1..1024.
    assign w_room = 11'((13'd4096 - {1'b0, r_addr[11:0]}) >> 2);

    always_comb begin
        w_len = 9'(MAX_BURST);
        if (r_remaining < 24'(w_len)) w_len = r_remaining[8:0];
        if (w_room < 11'(w_len))      w_len = w_room[8:0];
    end

    assign w_fifo_ok  = (fifo_level_i >= 11'(w_len));
    assign w_in_data  = (r_state == DATA);
    assign w_wvalid   = w_in_data & fifo_valid_i;
    assign w_w_hs     = w_wvalid & axi_wready_i;
    assign w_wlast    = w_in_data & (r_beat == 8'd0);
    assign w_rem_next = r_remaining - {15'd0, r_len};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_awlen     <= '0;
            r_beat      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        // A zero-length request completes without touching the bus.
                        if (words_i == 24'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr      <= {base_addr_i[31:2], 2'b00};
                            r_remaining <= words_i;
                            r_busy      <= 1'b1;
                            r_state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_fifo_ok) begin
                        r_len     <= w_len;
                        r_awlen   <= 8'(w_len - 9'd1);
                        r_awvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi_awready_i) begin
                        r_awvalid <= 1'b0;
                        r_beat    <= 8'(r_len - 9'd1);
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_w_hs) begin
                        if (r_beat == 8'd0) begin
                            r_bready <= 1'b1;
                            r_state  <= RESP;
                        end else begin
                            r_beat <= r_beat - 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (axi_bvalid_i) begin
                        r_bready    <= 1'b0;
                        r_addr      <= r_addr + {21'd0, r_len, 2'b00};
                        r_remaining <= w_rem_next;
                        if (w_rem_next == 24'd0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef JPEG_DMA_BRESP_CHECK_EN
    logic r_error;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_error <= 1'b0;
        end else if (r_state == IDLE && start_i) begin
            r_error <= 1'b0;
        end else if (r_bready && axi_bvalid_i && axi_bresp_i[1]) begin
            // bresp[1] set covers SLVERR (2'b10) and DECERR (2'b11).
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

    assign w_unused = ^{axi_bid_i, axi_bresp_i};

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign fifo_pop_o    = w_w_hs;
    assign axi_awvalid_o = r_awvalid;
    assign axi_awaddr_o  = r_addr;
    assign axi_awid_o    = 4'(AXI_ID);
    assign axi_awlen_o   = r_awlen;
    assign axi_awburst_o = 2'b01;
    assign axi_wvalid_o  = w_wvalid;
    assign axi_wdata_o   = w_in_data ? fifo_data_i : '0;
    assign axi_wstrb_o   = '1;
    assign axi_wlast_o   = w_wlast;
    assign axi_bready_o  = r_bready;

endmodule

// File: tb/tb_jpeg_decoder_output_dma.sv
module tb_jpeg_decoder_output_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [23:0] words = '0;
    logic        busy, done, error;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic [10:0] fifo_level;
    logic        fifo_pop;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awready = 1'b1;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    always #5 clk = ~clk;

    jpeg_decoder_output_dma #(.AXI_ID(0), .MAX_BURST(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .words_i(words),
        .busy_o(busy), .done_o(done), .error_o(error),
        .fifo_data_i(fifo_data), .fifo_valid_i(fifo_valid), .fifo_level_i(fifo_level),
        .fifo_pop_o(fifo_pop),
        .axi_awvalid_o(awvalid), .axi_awaddr_o(awaddr), .axi_awid_o(awid), .axi_awlen_o(awlen),
        .axi_awburst_o(awburst), .axi_awready_i(awready),
        .axi_wvalid_o(wvalid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_wready_i(wready),
        .axi_bvalid_i(bvalid), .axi_bresp_i(bresp), .axi_bid_i(4'd0), .axi_bready_o(bready)
    );

    // FIFO model: word k (k-th pop overall) carries {16'hD00D, k}.
    int unsigned wp = 0, rp = 0;
    int unsigned feed_total = 0, feed_gap = 0, feed_cnt = 0;
    assign fifo_level = 11'(wp - rp);
    assign fifo_valid = (wp != rp);
    assign fifo_data  = {16'hD00D, 16'(rp)};

    always @(posedge clk) begin
        if (fifo_pop) rp <= rp + 1;
        if (wp < feed_total) begin
            if (feed_cnt == 0) begin
                wp <= wp + 1;
                feed_cnt <= feed_gap;
            end else begin
                feed_cnt <= feed_cnt - 1;
            end
        end
    end

    // AXI slave model: wr_mode 0 = always ready, 1 = random, 2 = never ready.
    int          wr_mode = 0;
    int          bdelay = 0;
    int          bcnt;
    logic        bpend;
    logic [1:0]  bresp_cfg = 2'b00;
    assign bresp = bresp_cfg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wready <= 1'b0;
            bvalid <= 1'b0;
            bpend  <= 1'b0;
            bcnt   <= 0;
        end else begin
            wready <= (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (wvalid && wready && wlast) begin
                bpend <= 1'b1;
                bcnt  <= bdelay;
            end else if (bpend) begin
                if (bcnt == 0) begin
                    bvalid <= 1'b1;
                    bpend  <= 1'b0;
                end else begin
                    bcnt <= bcnt - 1;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
        end
    end

    // Bus monitor
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] wdat_q[$];
    logic        wlast_q[$];
    int          done_n = 0, lvl_bad = 0, wdrop_bad = 0;
    logic        prev_stall = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                if (int'(fifo_level) < int'(awlen) + 1) lvl_bad <= lvl_bad + 1;
            end
            if (wvalid && wready) begin
                wdat_q.push_back(wdata);
                wlast_q.push_back(wlast);
            end
            if (prev_stall && !wvalid) wdrop_bad <= wdrop_bad + 1;
            prev_stall <= wvalid && !wready;
            if (done) done_n <= done_n + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int a0, w0, d0, k;
    int unsigned r0;
    logic exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        a0 = aw_addr_q.size();
        w0 = wdat_q.size();
        d0 = done_n;
        r0 = rp;
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [23:0] w);
        base  = b;
        words = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    task automatic chk_data(input string tag, input int first, input int n);
        for (int i = first; i < first + n; i++)
            chk({tag, " wdata"}, wdat_q[i], {16'hD00D, 16'(i)});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef JPEG_DMA_BRESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst busy",    32'(busy),    32'd0);
        chk("rst done",    32'(done),    32'd0);
        chk("rst error",   32'(error),   32'd0);
        chk("rst awvalid", 32'(awvalid), 32'd0);
        chk("rst awaddr",  awaddr,       32'd0);
        chk("rst awlen",   32'(awlen),   32'd0);
        chk("rst awid",    32'(awid),    32'd0);
        chk("rst awburst", 32'(awburst), 32'd1);
        chk("rst wstrb",   32'(wstrb),   32'hF);
        chk("rst wvalid",  32'(wvalid),  32'd0);
        chk("rst wlast",   32'(wlast),   32'd0);
        chk("rst bready",  32'(bready),  32'd0);
        chk("rst pop",     32'(fifo_pop), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: 0x1000, 16 words, FIFO preloaded
        feed_total += 16;
        repeat (18) @(negedge clk);
        snap();
        start_xfer(32'h0000_1003, 24'd16);
        chk("t1 busy c1",    32'(busy),    32'd1);
        chk("t1 awvalid c1", 32'(awvalid), 32'd0);
        @(negedge clk);
        chk("t1 awvalid c2", 32'(awvalid), 32'd1);
        chk("t1 awaddr",     awaddr,       32'h0000_1000);
        chk("t1 awlen",      32'(awlen),   32'd15);
        wait_done("t1", 100);
        chk("t1 aw count", 32'(aw_addr_q.size() - a0), 32'd1);
        chk("t1 w count",  32'(wdat_q.size() - w0),    32'd16);
        chk("t1 done count", 32'(done_n - d0),         32'd1);
        chk("t1 wlast beat16", 32'(wlast_q[w0 + 15]),  32'd1);
        chk("t1 wlast beat15", 32'(wlast_q[w0 + 14]),  32'd0);
        chk_data("t1", w0, 16);

        // T2: 4KB boundary split
        feed_total += 8;
        repeat (10) @(negedge clk);
        snap();
        start_xfer(32'h0000_1FF8, 24'd8);
        wait_done("t2", 100);
        chk("t2 aw count", 32'(aw_addr_q.size() - a0), 32'd2);
        chk("t2 aw0 addr", aw_addr_q[a0],               32'h0000_1FF8);
        chk("t2 aw0 len",  32'(aw_len_q[a0]),           32'd1);
        chk("t2 aw1 addr", aw_addr_q[a0 + 1],           32'h0000_2000);
        chk("t2 aw1 len",  32'(aw_len_q[a0 + 1]),       32'd5);
        chk("t2 w count",  32'(wdat_q.size() - w0),     32'd8);
        chk_data("t2", w0, 8);

        // T3: 40 words, slow feed, random wready, delayed B
        wr_mode = 1;
        bdelay = 10;
        feed_gap = 2;
        feed_total += 40;
        snap();
        start_xfer(32'h0004_0000, 24'd40);
        wait_done("t3", 2000);
        chk("t3 aw count", 32'(aw_addr_q.size() - a0), 32'd3);
        chk("t3 aw0 addr", aw_addr_q[a0],               32'h0004_0000);
        chk("t3 aw1 addr", aw_addr_q[a0 + 1],           32'h0004_0040);
        chk("t3 aw2 addr", aw_addr_q[a0 + 2],           32'h0004_0080);
        chk("t3 aw0 len",  32'(aw_len_q[a0]),           32'd15);
        chk("t3 aw1 len",  32'(aw_len_q[a0 + 1]),       32'd15);
        chk("t3 aw2 len",  32'(aw_len_q[a0 + 2]),       32'd7);
        chk("t3 pop count", rp - r0,                    32'd40);
        chk("t3 w count",  32'(wdat_q.size() - w0),     32'd40);
        chk("t3 level ok at aw", 32'(lvl_bad),          32'd0);
        chk("t3 wvalid stable",  32'(wdrop_bad),        32'd0);
        chk("t3 wlast b1", 32'(wlast_q[w0 + 15]),       32'd1);
        chk("t3 wlast b3", 32'(wlast_q[w0 + 39]),       32'd1);
        chk_data("t3", w0, 40);

        // T4: error response
        wr_mode = 0;
        bdelay = 0;
        feed_gap = 0;
        feed_total += 4;
        repeat (6) @(negedge clk);
        bresp_cfg = 2'b10;
        snap();
        start_xfer(32'h0000_0100, 24'd4);
        wait_done("t4", 100);
        chk("t4 error set", 32'(error), 32'(exp_err));
        repeat (3) @(negedge clk);
        chk("t4 error sticky", 32'(error), 32'(exp_err));
        bresp_cfg = 2'b00;
        start_xfer(32'h0, 24'd0);
        chk("t4 error cleared", 32'(error), 32'd0);
        chk("t4 zero-len done", 32'(done),  32'd1);
        @(negedge clk);

        // T5: reset mid-DATA, then zero-length start
        wr_mode = 2;
        feed_total += 16;
        repeat (18) @(negedge clk);
        start_xfer(32'h0000_3000, 24'd16);
        k = 0;
        while (wvalid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5 in DATA", 32'(wvalid), 32'd1);
        snap();
        #1 rst = 1'b1;
        #1;
        chk("t5 rst awvalid", 32'(awvalid), 32'd0);
        chk("t5 rst wvalid",  32'(wvalid),  32'd0);
        chk("t5 rst bready",  32'(bready),  32'd0);
        chk("t5 rst busy",    32'(busy),    32'd0);
        chk("t5 rst pop",     32'(fifo_pop), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_mode = 0;
        @(negedge clk);
        chk("t5 fifo untouched", 32'(fifo_level), 32'd16);
        start_xfer(32'h0000_5000, 24'd0);
        chk("t5 zero done", 32'(done), 32'd1);
        chk("t5 zero busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t5 zero done pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("t5 no aw",  32'(aw_addr_q.size() - a0), 32'd0);
        chk("t5 no w",   32'(wdat_q.size() - w0),    32'd0);
        chk("t5 no pop", rp - r0,                    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
